video_sprite_overlay: RTL and testbench

Parametrised multi-sprite overlay stage inserted between the video formatter's scanout pipeline and the DVI encoder, all in the dvi_clk domain. It generalises the single 32x48 cursor to NUM_SPRITES independent sprites with per-sprite enable, 2x scaling, fixed-index priority and colour-key transparency. Position and enable changes are double-buffered so they take effect only at frame start.

---
 rtl/video_fmt_pkg.sv | 13 +
 rtl/sprite_unit.sv | 107 ++++++++++
 rtl/video_sprite_overlay.sv | 115 +++++++++++
 tb/tb_video_sprite_overlay.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_fmt_pkg.sv
// Shared definitions for the video formatter control path and the sprite overlay.
package video_fmt_pkg;

  typedef enum logic [7:0] {
    OP_SPRITEXY    = 8'd13,
    OP_SPRITE_ADDR = 8'd14,
    OP_SPRITE_DATA = 8'd15,
    OP_SPRITE_CFG  = 8'd16
  } ctrl_op_e;

  localparam logic [23:0] KEY_COLOR_DEFAULT = 24'hFF00FF;

endpackage

// File: rtl/sprite_unit.sv
// One overlay sprite: double-buffered position/config, hit and address generation, pixel RAM.
module sprite_unit
  import video_fmt_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 48,
  parameter int COORD_W  = 12,
  parameter int PIX_W    = 24
) (
  input  logic               dvi_clk,
  input  logic               areset,
  input  logic               wr_en,
  input  logic [7:0]         ctrl_op,
  input  logic [31:0]        ctrl_data,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               in_active,
  output logic               hit,
  output logic [PIX_W-1:0]   pix
);

  localparam int DEPTH  = SPRITE_W * SPRITE_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int XW     = $clog2(SPRITE_W);
  localparam int ROW_W  = ADDR_W - XW;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COORD_W-1:0] W_LIM     = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(SPRITE_H);

  logic [COORD_W-1:0] shadow_x, shadow_y, live_x, live_y;
  logic               shadow_en, shadow_scale, live_en, live_scale;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic               hit1;
  logic [PIX_W-1:0]   mem [DEPTH];

  logic [COORD_W-1:0] dx, dy, dxs, dys;
  logic               hit_c;
  logic               unused_ctrl;

  assign unused_ctrl = ^ctrl_data;

  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_en    <= 1'b0;
      shadow_scale <= 1'b0;
      live_x       <= '0;
      live_y       <= '0;
      live_en      <= 1'b0;
      live_scale   <= 1'b0;
      wr_addr      <= '0;
    end else begin
      // Live takes the pre-write shadow value when a write coincides with frame start.
      if (frame_start) begin
        live_x     <= shadow_x;
        live_y     <= shadow_y;
        live_en    <= shadow_en;
        live_scale <= shadow_scale;
      end
      if (wr_en) begin
        case (ctrl_op)
          OP_SPRITEXY: begin
            shadow_y <= ctrl_data[COORD_W+15:16];
            shadow_x <= ctrl_data[COORD_W-1:0];
          end
          OP_SPRITE_CFG: begin
            shadow_en    <= ctrl_data[0];
            shadow_scale <= ctrl_data[1];
          end
          OP_SPRITE_ADDR: wr_addr <= ctrl_data[ADDR_W-1:0];
          OP_SPRITE_DATA: wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dx    = x - live_x;
    dy    = y - live_y;
    dxs   = live_scale ? (dx >> 1) : dx;
    dys   = live_scale ? (dy >> 1) : dy;
    hit_c = live_en && in_active && (x >= live_x) && (y >= live_y) &&
            (dxs < W_LIM) && (dys < H_LIM);
  end

  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      hit1    <= 1'b0;
      rd_addr <= '0;
      hit     <= 1'b0;
    end else begin
      hit1    <= hit_c;
      rd_addr <= {dys[ROW_W-1:0], dxs[XW-1:0]};
      hit     <= hit1;
    end
  end

  always_ff @(posedge dvi_clk) begin
    if (wr_en && (ctrl_op == OP_SPRITE_DATA))
      mem[wr_addr] <= ctrl_data[PIX_W-1:0];
    pix <= mem[rd_addr];
  end

endmodule

// File: rtl/video_sprite_overlay.sv
// Multi-sprite overlay between scanout and the DVI encoder; fixed 3-cycle latency, index 0 on top.
module video_sprite_overlay
  import video_fmt_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 48,
  parameter int COORD_W     = 12,
  parameter int PIX_W       = 24,
  parameter logic [PIX_W-1:0] KEY_COLOR = PIX_W'(KEY_COLOR_DEFAULT),
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic             dvi_clk,
  input  logic             areset,
  input  logic [PIX_W-1:0] in_rgb,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_active,
  input  logic             ctrl_strobe,
  input  logic [7:0]       ctrl_op,
  input  logic [SEL_W-1:0] ctrl_sel,
  input  logic [31:0]      ctrl_data,
  output logic [PIX_W-1:0] out_rgb,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_active
);

  localparam logic [COORD_W-1:0] CMAX = '1;

  logic               vs_q, act_q;
  logic [COORD_W-1:0] x, y;
  logic               frame_start, line_end;
  logic [PIX_W-1:0]   rgb_d1, rgb_d2, mux_rgb;
  logic [2:0]         sync_d1, sync_d2;
  logic [NUM_SPRITES-1:0] hit2;
  logic [PIX_W-1:0]   pix2 [NUM_SPRITES];

  assign frame_start = in_vsync && !vs_q;
  assign line_end    = !in_active && act_q;

  // Counters saturate so a sprite can never alias onto a wrapped coordinate.
  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      vs_q  <= 1'b0;
      act_q <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else begin
      vs_q  <= in_vsync;
      act_q <= in_active;
      if (in_active) begin
        if (x != CMAX) x <= x + COORD_W'(1);
      end else begin
        x <= '0;
      end
      if (frame_start)
        y <= '0;
      else if (line_end && (y != CMAX))
        y <= y + COORD_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic wr_en;
    assign wr_en = ctrl_strobe && (32'(ctrl_sel) == i);

    sprite_unit #(
      .SPRITE_W(SPRITE_W),
      .SPRITE_H(SPRITE_H),
      .COORD_W (COORD_W),
      .PIX_W   (PIX_W)
    ) u_spr (
      .dvi_clk    (dvi_clk),
      .areset     (areset),
      .wr_en      (wr_en),
      .ctrl_op    (ctrl_op),
      .ctrl_data  (ctrl_data),
      .frame_start(frame_start),
      .x          (x),
      .y          (y),
      .in_active  (in_active),
      .hit        (hit2[i]),
      .pix        (pix2[i])
    );
  end

  always_comb begin
    mux_rgb = rgb_d2;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit2[i] && (pix2[i] != KEY_COLOR)) mux_rgb = pix2[i];
    end
  end

  always_ff @(posedge dvi_clk or posedge areset) begin
    if (areset) begin
      rgb_d1     <= '0;
      rgb_d2     <= '0;
      sync_d1    <= '0;
      sync_d2    <= '0;
      out_rgb    <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_active <= 1'b0;
    end else begin
      rgb_d1  <= in_rgb;
      rgb_d2  <= rgb_d1;
      sync_d1 <= {in_hsync, in_vsync, in_active};
      sync_d2 <= sync_d1;
      out_rgb <= mux_rgb;
      {out_hsync, out_vsync, out_active} <= sync_d2;
    end
  end

endmodule

// File: tb/tb_video_sprite_overlay.sv
// Directed bench for video_sprite_overlay: per-frame pixel probe table plus sync/latency stream check.
module tb_video_sprite_overlay;

  localparam int NS = 3;
  localparam logic [23:0] BG        = 24'h123456;
  localparam logic [23:0] BLANK_RGB = 24'h0BEEF0;
  localparam logic [23:0] KEY       = 24'hFF00FF;
  localparam logic [7:0]  OP_XY = 8'd13, OP_ADDR = 8'd14, OP_DATA = 8'd15, OP_CFG = 8'd16;

  logic        dvi_clk = 1'b0;
  logic        areset;
  logic [23:0] in_rgb;
  logic        in_hsync, in_vsync, in_active;
  logic        ctrl_strobe;
  logic [7:0]  ctrl_op;
  logic [1:0]  ctrl_sel;
  logic [31:0] ctrl_data;
  logic [23:0] out_rgb;
  logic        out_hsync, out_vsync, out_active;

  video_sprite_overlay #(.NUM_SPRITES(NS)) dut (
    .dvi_clk    (dvi_clk),
    .areset     (areset),
    .in_rgb     (in_rgb),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_active  (in_active),
    .ctrl_strobe(ctrl_strobe),
    .ctrl_op    (ctrl_op),
    .ctrl_sel   (ctrl_sel),
    .ctrl_data  (ctrl_data),
    .out_rgb    (out_rgb),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .out_active (out_active)
  );

  always #5 dvi_clk = ~dvi_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Stream monitor: outputs must equal inputs from three cycles earlier.
  int          tag_x = 0, tag_y = 0;
  int          vcnt = 0;
  int          sync_err = 0;
  logic [23:0] h_rgb [3];
  logic        h_hs [3], h_vs [3], h_act [3];
  int          h_x [3], h_y [3];
  logic [23:0] pix_cap [int];

  always @(negedge dvi_clk) begin
    if (areset) begin
      vcnt = 0;
    end else begin
      if (vcnt >= 3) begin
        if ({out_hsync, out_vsync, out_active} !== {h_hs[2], h_vs[2], h_act[2]}) sync_err++;
        if (h_act[2]) pix_cap[h_y[2] * 4096 + h_x[2]] = out_rgb;
        else if (out_rgb !== h_rgb[2]) sync_err++;
      end
      for (int k = 2; k > 0; k--) begin
        h_rgb[k] = h_rgb[k-1]; h_hs[k] = h_hs[k-1]; h_vs[k] = h_vs[k-1];
        h_act[k] = h_act[k-1]; h_x[k] = h_x[k-1]; h_y[k] = h_y[k-1];
      end
      h_rgb[0] = in_rgb; h_hs[0] = in_hsync; h_vs[0] = in_vsync;
      h_act[0] = in_active; h_x[0] = tag_x; h_y[0] = tag_y;
      if (vcnt < 3) vcnt++;
    end
  end

  typedef struct {
    int          phase;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic v(input int p, input int x, input int y, input logic [23:0] e);
    vec_t t;
    t.phase = p; t.x = x; t.y = y; t.exp = e;
    vecs.push_back(t);
  endtask

  int          fc = 0, fw_cyc = -1, fw_sel = 0;
  logic [7:0]  fw_op = 8'd0;
  logic [31:0] fw_data = 32'd0;

  function automatic logic [31:0] xy(input int x, input int y);
    return (32'(y) << 16) | 32'(x);
  endfunction

  task automatic step(input logic hs, input logic vs, input logic act, input int tx, input int ty);
    in_hsync = hs; in_vsync = vs; in_active = act;
    in_rgb = act ? BG : BLANK_RGB;
    tag_x = tx; tag_y = ty;
    ctrl_strobe = (fc == fw_cyc);
    ctrl_op = fw_op; ctrl_sel = 2'(fw_sel); ctrl_data = fw_data;
    fc++;
    @(posedge dvi_clk); #1;
    ctrl_strobe = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] op, input int sel, input logic [31:0] d);
    in_hsync = 1'b0; in_vsync = 1'b0; in_active = 1'b0; in_rgb = BLANK_RGB;
    ctrl_strobe = 1'b1; ctrl_op = op; ctrl_sel = 2'(sel); ctrl_data = d;
    @(posedge dvi_clk); #1;
    ctrl_strobe = 1'b0;
  endtask

  task automatic fill(input int sel, input bit ramp, input logic [23:0] val);
    ctrl_write(OP_ADDR, sel, 32'd0);
    for (int k = 0; k < 32 * 48; k++)
      ctrl_write(OP_DATA, sel, ramp ? 32'(k) : 32'(val));
  endtask

  task automatic run_probes(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        int key;
        logic [23:0] got;
        key = vecs[i].y * 4096 + vecs[i].x;
        got = pix_cap.exists(key) ? pix_cap[key] : 24'hxxxxxx;
        check($sformatf("p%0d_pix(%0d,%0d)", p, vecs[i].x, vecs[i].y), 32'(got), 32'(vecs[i].exp));
      end
    end
  endtask

  task automatic run_frame(input int p, input int w, input int h, input int wc,
                           input logic [7:0] op, input int sel, input logic [31:0] d);
    pix_cap.delete();
    fc = 0; fw_cyc = wc; fw_op = op; fw_sel = sel; fw_data = d;
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) step(0, 0, 1, xx, yy);
      for (int b = 0; b < 4; b++) step(b == 1 || b == 2, 0, 0, 0, 0);
    end
    for (int b = 0; b < 4; b++) step(0, 0, 0, 0, 0);
    fw_cyc = -1;
    check($sformatf("p%0d_sync_align", p), 32'(sync_err), 32'd0);
    sync_err = 0;
    run_probes(p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // phase 1: single sprite
    v(1, 100, 50, 24'h00FF00); v(1, 131, 97, 24'h00FF00); v(1, 115, 70, 24'h00FF00);
    v(1, 99, 50, BG); v(1, 132, 50, BG); v(1, 100, 49, BG); v(1, 100, 98, BG); v(1, 0, 0, BG);
    // phase 2/3: overlap and colour key
    v(2, 10, 10, 24'hABCDEF); v(2, 41, 19, 24'hABCDEF); v(2, 42, 10, BG); v(2, 9, 12, BG); v(2, 10, 9, BG);
    v(3, 10, 10, 24'h111111); v(3, 11, 10, 24'hABCDEF);
    // phase 4: 2x scaling
    v(4, 3, 5, 24'h000041); v(4, 0, 0, 24'h0); v(4, 1, 1, 24'h0); v(4, 2, 0, 24'h1); v(4, 2, 2, 24'h21);
    v(4, 63, 95, 24'h5FF); v(4, 62, 94, 24'h5FF); v(4, 64, 0, BG); v(4, 0, 96, BG);
    // phases 5-8: double-buffered moves
    v(5, 0, 0, 24'h0); v(5, 30, 12, 24'h19E); v(5, 31, 13, 24'h1BF);
    v(6, 30, 12, 24'h0); v(6, 31, 13, 24'h21); v(6, 0, 0, BG); v(6, 29, 12, BG);
    v(7, 30, 12, 24'h0); v(7, 5, 3, BG);
    v(8, 5, 3, 24'h0); v(8, 30, 12, 24'h139); v(8, 4, 3, BG);
    // phase 9: write-address wrap
    v(9, 31, 47, 24'hAAA001); v(9, 0, 0, 24'hAAA002); v(9, 1, 0, 24'hAAA003);
    v(9, 2, 0, 24'h2); v(9, 30, 47, 24'h5FE);
    // phase 10: right-edge clipping
    v(10, 1270, 0, 24'hAAA002); v(10, 1271, 0, 24'hAAA003); v(10, 1279, 0, 24'h9);
    v(10, 1269, 0, BG); v(10, 0, 1, BG); v(10, 1, 1, BG); v(10, 1271, 1, 24'h21);
    // phases 11/12: after mid-line reset
    v(11, 3, 0, BG); v(11, 5, 1, BG);
    v(12, 0, 0, 24'hAAA002); v(12, 3, 0, 24'h3); v(12, 32, 0, BG);

    areset = 1'b1; in_rgb = BG; in_hsync = 1'b1; in_vsync = 1'b0; in_active = 1'b1;
    ctrl_strobe = 1'b0; ctrl_op = 8'd0; ctrl_sel = 2'd0; ctrl_data = 32'd0;
    repeat (3) @(posedge dvi_clk);
    #1;
    check("reset_rgb", 32'(out_rgb), 32'd0);
    check("reset_hsync", 32'(out_hsync), 32'd0);
    check("reset_vsync", 32'(out_vsync), 32'd0);
    check("reset_active", 32'(out_active), 32'd0);
    in_hsync = 1'b0; in_active = 1'b0; in_rgb = BLANK_RGB;
    @(posedge dvi_clk); #1;
    areset = 1'b0;

    fill(0, 1'b0, 24'h00FF00);
    ctrl_write(OP_XY, 0, xy(100, 50));
    ctrl_write(OP_CFG, 0, 32'd1);
    run_frame(1, 140, 100, -1, 8'd0, 0, 32'd0);

    fill(0, 1'b0, KEY);
    fill(1, 1'b0, 24'hABCDEF);
    ctrl_write(OP_XY, 0, xy(10, 10));
    ctrl_write(OP_XY, 1, xy(10, 10));
    ctrl_write(OP_CFG, 1, 32'd1);
    run_frame(2, 50, 20, -1, 8'd0, 0, 32'd0);
    ctrl_write(OP_ADDR, 0, 32'd0);
    ctrl_write(OP_DATA, 0, 32'h111111);
    run_frame(3, 50, 20, -1, 8'd0, 0, 32'd0);

    ctrl_write(OP_CFG, 0, 32'd0);
    ctrl_write(OP_CFG, 1, 32'd0);
    fill(2, 1'b1, 24'h0);
    ctrl_write(OP_XY, 2, xy(0, 0));
    ctrl_write(OP_CFG, 2, 32'd3);
    run_frame(4, 70, 98, -1, 8'd0, 0, 32'd0);

    ctrl_write(OP_CFG, 2, 32'd1);
    run_frame(5, 60, 20, 4 + 5 * 64 + 10, OP_XY, 2, xy(30, 12));
    run_frame(6, 60, 20, -1, 8'd0, 0, 32'd0);
    run_frame(7, 60, 20, 0, OP_XY, 2, xy(5, 3));
    run_frame(8, 60, 20, -1, 8'd0, 0, 32'd0);

    ctrl_write(OP_XY, 2, xy(0, 0));
    ctrl_write(OP_ADDR, 2, 32'd1535);
    ctrl_write(OP_DATA, 2, 32'hAAA001);
    ctrl_write(OP_DATA, 2, 32'hAAA002);
    ctrl_write(OP_DATA, 2, 32'hAAA003);
    ctrl_write(OP_XY, 3, xy(20, 20));
    ctrl_write(OP_CFG, 3, 32'd0);
    ctrl_write(OP_DATA, 3, 32'h777777);
    run_frame(9, 36, 48, -1, 8'd0, 0, 32'd0);

    ctrl_write(OP_XY, 2, xy(1270, 0));
    run_frame(10, 1280, 2, -1, 8'd0, 0, 32'd0);

    ctrl_write(OP_XY, 2, xy(3, 0));
    fc = 0; fw_cyc = -1;
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 1, k, 0);
    check("pre_reset_rgb", 32'(out_rgb), 32'd4);
    check("pre_reset_active", 32'(out_active), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    check("async_reset_rgb", 32'(out_rgb), 32'd0);
    check("async_reset_active", 32'(out_active), 32'd0);
    check("async_reset_hsync", 32'(out_hsync), 32'd0);
    check("async_reset_vsync", 32'(out_vsync), 32'd0);
    in_active = 1'b0; in_rgb = BLANK_RGB;
    repeat (2) @(posedge dvi_clk);
    #1;
    areset = 1'b0;
    run_frame(11, 40, 4, -1, 8'd0, 0, 32'd0);
    ctrl_write(OP_CFG, 2, 32'd1);
    run_frame(12, 40, 4, -1, 8'd0, 0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
